// File: rtl/fir_adder_tree_if.sv
// rtl/fir_adder_tree_if.sv - sample-in / sum-out bundle for the FIR adder tree
interface fir_adder_tree_if #(
   parameter int N      = 32,
   parameter int NUM_IN = 8,
   parameter int OUT_W  = 32
);
   logic                    in_valid;
   logic [N*NUM_IN-1:0]     in_data;
   logic                    out_valid;
   logic signed [OUT_W-1:0] out_data;
   logic                    ovf;

   modport master (
      output in_valid, in_data,
      input  out_valid, out_data, ovf
   );

   modport slave (
      input  in_valid, in_data,
      output out_valid, out_data, ovf
   );
endinterface

// File: rtl/fir_adder_tree.sv
// rtl/fir_adder_tree.sv - pipelined signed adder tree with saturate/wrap output stage
module fir_adder_tree #(
   parameter int N      = 32,
   parameter int NUM_IN = 8,
   parameter int OUT_W  = 32,
   parameter bit SAT    = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   fir_adder_tree_if.slave bus
);
   localparam int LEVELS = (NUM_IN > 1) ? $clog2(NUM_IN) : 0;
   localparam int PAD    = 1 << LEVELS;
   localparam int FW     = N + LEVELS;
   localparam int LAT    = LEVELS + 1;

   logic signed [FW-1:0]    in_ext [PAD];
   logic signed [FW-1:0]    full_sum;
   logic signed [OUT_W-1:0] out_d;
   logic signed [OUT_W-1:0] out_q;
   logic                    ovf_d;
   logic                    ovf_q;
   logic [LAT-1:0]          vld_q;

   for (genvar j = 0; j < PAD; j++) begin : g_ext
      if (j < NUM_IN) begin : g_op
         logic signed [N-1:0] op;
         assign op        = bus.in_data[j*N +: N];
         assign in_ext[j] = FW'(op);
      end else begin : g_pad
         assign in_ext[j] = '0;
      end
   end

   // Level k holds PAD>>k partial sums; FW bits leave room for every carry.
   for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
      localparam int W = PAD >> k;
      logic signed [FW-1:0] node_q [W];
      logic signed [FW-1:0] src    [2*W];

      if (k == 1) begin : g_src_in
         assign src = in_ext;
      end else begin : g_src_lvl
         assign src = g_lvl[k-1].node_q;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int j = 0; j < W; j++) node_q[j] <= '0;
         end else if (en) begin
            for (int j = 0; j < W; j++) node_q[j] <= src[2*j] + src[2*j+1];
         end
      end
   end

   if (LEVELS == 0) begin : g_flat
      assign full_sum = in_ext[0];
   end else begin : g_root
      assign full_sum = g_lvl[LEVELS].node_q[0];
   end

   if (OUT_W >= FW) begin : g_widen
      assign out_d = OUT_W'(full_sum);
      assign ovf_d = 1'b0;
   end else begin : g_reduce
      // The sum fits iff every bit from OUT_W-1 upward is a copy of the sign.
      logic [FW-OUT_W:0] top;
      logic              out_range;
      assign top       = full_sum[FW-1:OUT_W-1];
      assign out_range = !((&top) || !(|top));
      assign ovf_d     = out_range;
      if (SAT) begin : g_sat
         assign out_d = !out_range    ? full_sum[OUT_W-1:0] :
                        full_sum[FW-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                         {1'b0, {(OUT_W-1){1'b1}}};
      end else begin : g_wrap
         assign out_d = full_sum[OUT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= '0;
         ovf_q <= 1'b0;
         vld_q <= '0;
      end else if (en) begin
         out_q <= out_d;
         ovf_q <= ovf_d;
         vld_q <= LAT'({vld_q, bus.in_valid});
      end
   end

   assign bus.out_data  = out_q;
   assign bus.ovf       = ovf_q;
   assign bus.out_valid = vld_q[LAT-1];
endmodule
